branch_predictor: RTL

Parametrised branch target buffer with per-entry saturating direction counters for the RISC-V core front end. The IF stage looks it up every cycle to choose the next fetch PC. The EX stage trains it with resolved branch outcomes. It also produces the mispredict flush and redirect PC, so pipeline flushes happen only on wrong predictions instead of on every taken branch.

---
 rtl/core_pkg.sv | 32 +++
 rtl/bp_sat_counter.sv | 31 +++
 rtl/branch_predictor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the RISC-V core.
//   ADDR_WIDTH / DATA_WIDTH : architectural PC and data widths.
//   BP_ENTRIES / BP_CNT_WIDTH : default branch predictor geometry.
//   bp_tag_width()           : tag width left after the index and byte bits.
//   bp_entry_t               : one BTB entry laid out for the default geometry.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam int BP_ENTRIES   = 16;
  localparam int BP_CNT_WIDTH = 2;

  // Instructions are word aligned, so the two low PC bits never take part
  // in indexing; the tag is whatever remains above the index field.
  function automatic int bp_tag_width(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

  localparam int BP_TAG_WIDTH = bp_tag_width(ADDR_WIDTH, BP_ENTRIES);

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_WIDTH-1:0] tag;
    logic [ADDR_WIDTH-1:0]   target;
    logic [BP_CNT_WIDTH-1:0] cnt;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Next-state function of a WIDTH-bit saturating up/down direction counter.
//   cnt_i : current counter value
//   inc_i : 1 = count up (branch taken), 0 = count down (not taken)
//   cnt_o : next counter value, held at all-ones / zero at the ends
// ---------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  // Move one step toward the observed direction, but never wrap: a strongly
  // biased branch must stay strongly biased rather than flip to the other end.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != '1) begin
        cnt_o = cnt_i + 1'b1;
      end
    end else begin
      if (cnt_i != '0) begin
        cnt_o = cnt_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with saturating direction counters.
// IF looks it up every cycle; EX trains it and gets the mispredict flush.
//
// Ports
//   clk, rst                : core clock, synchronous active-high reset
//   if_pc_i                 : PC being fetched
//   if_pred_taken_o         : lookup predicts taken
//   if_pred_target_o        : predicted next fetch PC
//   ex_valid_i              : EX holds a valid resolved branch/jump
//   ex_pc_i, ex_taken_i,
//   ex_target_i             : resolved PC, direction and taken target
//   ex_pred_taken_i,
//   ex_pred_target_i        : prediction carried down the pipe
//   mispredict_o            : flush IF/ID and ID/EX this cycle
//   redirect_pc_o           : correct next PC while mispredict_o is high
//
// Optional feature (macro BP_STATS_EN)
//   stat_branches_o, stat_mispredicts_o : 32-bit saturating event counters.
// ---------------------------------------------------------------------------
module branch_predictor
  import core_pkg::*;
#(
  parameter int ENTRIES   = BP_ENTRIES,
  parameter int CNT_WIDTH = BP_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_pc_i,
  output logic                  if_pred_taken_o,
  output logic [ADDR_WIDTH-1:0] if_pred_target_o,
  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_pc_i,
  input  logic                  ex_taken_i,
  input  logic [ADDR_WIDTH-1:0] ex_target_i,
  input  logic                  ex_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target_i,
  output logic                  mispredict_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           stat_branches_o,
  output logic [31:0]           stat_mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = bp_tag_width(ADDR_WIDTH, ENTRIES);

  // Counter encodings: MSB is the predicted direction.
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [ADDR_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0]  cnt;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};

  entry_t table_q [ENTRIES];
  entry_t table_d [ENTRIES];

  logic [IDX_W-1:0]     if_idx;
  logic [TAG_W-1:0]     if_tag;
  entry_t               if_entry;
  logic                 if_hit;

  logic [IDX_W-1:0]     ex_idx;
  logic [TAG_W-1:0]     ex_tag;
  entry_t               ex_entry;
  logic                 ex_hit;
  logic [CNT_WIDTH-1:0] ex_cnt_next;

  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{if_pc_i[1:0], ex_pc_i[1:0]};

  // Lookup side: read straight from the registered table so an update in
  // the same cycle is not bypassed into the prediction.
  assign if_idx   = if_pc_i[IDX_W+1:2];
  assign if_tag   = if_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign if_entry = table_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

  always_comb begin
    if_pred_taken_o  = if_hit && if_entry.cnt[CNT_WIDTH-1];
    if_pred_target_o = if_pc_i + PC_STEP;
    if (if_pred_taken_o) begin
      if_pred_target_o = if_entry.target;
    end
  end

  // Resolve side: a wrong direction, or a taken branch going somewhere other
  // than where fetch went, both need a flush.
  always_comb begin
    mispredict_o  = 1'b0;
    redirect_pc_o = ex_pc_i + PC_STEP;
    if (ex_taken_i) begin
      redirect_pc_o = ex_target_i;
    end
    if (ex_valid_i) begin
      mispredict_o = (ex_taken_i != ex_pred_taken_i) ||
                     (ex_taken_i && (ex_target_i != ex_pred_target_i));
    end
  end

  assign ex_idx   = ex_pc_i[IDX_W+1:2];
  assign ex_tag   = ex_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign ex_entry = table_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  bp_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .cnt_i (ex_entry.cnt),
    .inc_i (ex_taken_i),
    .cnt_o (ex_cnt_next)
  );

  // Training: hits move their counter; taken hits also refresh the target
  // (indirect jumps can change it). Misses allocate only when taken, so
  // never-taken branches do not evict useful entries.
  always_comb begin
    table_d = table_q;
    if (ex_valid_i) begin
      if (ex_hit) begin
        table_d[ex_idx].cnt = ex_cnt_next;
        if (ex_taken_i) begin
          table_d[ex_idx].target = ex_target_i;
        end
      end else if (ex_taken_i) begin
        table_d[ex_idx] = '{valid: 1'b1, tag: ex_tag, target: ex_target_i, cnt: CNT_WEAK_T};
      end
    end
  end

  // The table lives in flops so the whole thing clears in one reset cycle;
  // reset takes priority over any update presented in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= RESET_ENTRY;
      end
    end else begin
      table_q <= table_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_branches_d;
  logic [31:0] stat_mispredicts_q;
  logic [31:0] stat_mispredicts_d;

  // Event counters hold at all-ones instead of wrapping so a long run never
  // reports a misleadingly small count.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (ex_valid_i && (stat_branches_q != '1)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict_o && (stat_mispredicts_q != '1)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches_o    = stat_branches_q;
  assign stat_mispredicts_o = stat_mispredicts_q;
`endif

endmodule
